// File: rtl/boot_handover_pkg.sv
// Shared types and constants for the boot handover sequencer and its bus mux.
package boot_pkg;

    localparam int unsigned BOOT_CNT_W  = 16;
    localparam int unsigned BOOT_ADDR_W = 16;

    // Sequencer states; 3-bit encoding kept stable for anyone probing the state.
    typedef enum logic [2:0] {
        ST_RESET_COPIER = 3'd0,
        ST_COPY         = 3'd1,
        ST_GAP          = 3'd2,
        ST_CPU_RESET    = 3'd3,
        ST_RUN          = 3'd4,
        ST_FAULT        = 3'd5
    } boot_state_e;

    // Which agent currently drives the shared memory bus.
    typedef enum logic [1:0] {
        OWNER_NONE   = 2'd0,
        OWNER_COPIER = 2'd1,
        OWNER_CPU    = 2'd2
    } bus_owner_e;

    // Memory-side bus as seen by the RAM and EEPROM.
    typedef struct packed {
        logic [BOOT_ADDR_W-1:0] address;
        logic                   ram_cs_n;
        logic                   ram_we_n;
        logic                   ram_oe_n;
        logic                   eeprom_cs_n;
        logic                   eeprom_oe_n;
    } mem_bus_t;

    // Nobody selected: address parked at zero, every strobe inactive.
    localparam mem_bus_t BUS_IDLE = '{
        address:     '0,
        ram_cs_n:    1'b1,
        ram_we_n:    1'b1,
        ram_oe_n:    1'b1,
        eeprom_cs_n: 1'b1,
        eeprom_oe_n: 1'b1
    };

endpackage

// File: rtl/boot_handover_if.sv
// Copier, CPU and memory-side signals of the boot handover block.
interface boot_handover_if;
    import boot_pkg::*;

    logic                   copier_reset_n;
    logic [BOOT_ADDR_W-1:0] copier_address;
    logic                   copier_ram_we_n;
    logic                   copier_ram_cs_n;
    logic                   copier_eeprom_oe_n;
    logic                   copier_eeprom_cs_n;
    logic                   copier_done;

    logic [BOOT_ADDR_W-1:0] cpu_address;
    logic                   cpu_mreq_n;
    logic                   cpu_rd_n;
    logic                   cpu_wr_n;
    logic                   cpu_reset_n;

    logic [BOOT_ADDR_W-1:0] address;
    logic                   ram_cs_n;
    logic                   ram_we_n;
    logic                   ram_oe_n;
    logic                   eeprom_cs_n;
    logic                   eeprom_oe_n;

    logic                   booted;
    logic                   fault;

    // Sequencer side: owns resets and the memory bus.
    modport master (
        output copier_reset_n,
        input  copier_address, copier_ram_we_n, copier_ram_cs_n,
        input  copier_eeprom_oe_n, copier_eeprom_cs_n, copier_done,
        input  cpu_address, cpu_mreq_n, cpu_rd_n, cpu_wr_n,
        output cpu_reset_n,
        output address, ram_cs_n, ram_we_n, ram_oe_n, eeprom_cs_n, eeprom_oe_n,
        output booted, fault
    );

    // Surrounding system: copier, CPU and memories.
    modport slave (
        input  copier_reset_n,
        output copier_address, copier_ram_we_n, copier_ram_cs_n,
        output copier_eeprom_oe_n, copier_eeprom_cs_n, copier_done,
        output cpu_address, cpu_mreq_n, cpu_rd_n, cpu_wr_n,
        input  cpu_reset_n,
        input  address, ram_cs_n, ram_we_n, ram_oe_n, eeprom_cs_n, eeprom_oe_n,
        input  booted, fault
    );

endinterface

// File: rtl/boot_handover_bus_mux.sv
// Combinational memory bus owner select: idle, copier, or CPU strobes.
module boot_bus_mux
    import boot_pkg::*;
(
    input  bus_owner_e             owner,
    input  logic [BOOT_ADDR_W-1:0] copier_address,
    input  logic                   copier_ram_we_n,
    input  logic                   copier_ram_cs_n,
    input  logic                   copier_eeprom_oe_n,
    input  logic                   copier_eeprom_cs_n,
    input  logic [BOOT_ADDR_W-1:0] cpu_address,
    input  logic                   cpu_mreq_n,
    input  logic                   cpu_rd_n,
    input  logic                   cpu_wr_n,
    output mem_bus_t               bus_out
);

    // Route the selected agent onto the bus; the CPU never sees the EEPROM.
    always_comb begin
        bus_out = BUS_IDLE;
        case (owner)
            OWNER_COPIER: begin
                bus_out.address     = copier_address;
                bus_out.ram_cs_n    = copier_ram_cs_n;
                bus_out.ram_we_n    = copier_ram_we_n;
                bus_out.ram_oe_n    = 1'b1;
                bus_out.eeprom_cs_n = copier_eeprom_cs_n;
                bus_out.eeprom_oe_n = copier_eeprom_oe_n;
            end
            OWNER_CPU: begin
                bus_out.address     = cpu_address;
                bus_out.ram_cs_n    = cpu_mreq_n;
                bus_out.ram_oe_n    = cpu_mreq_n | cpu_rd_n;
                bus_out.ram_we_n    = cpu_mreq_n | cpu_wr_n;
                bus_out.eeprom_cs_n = 1'b1;
                bus_out.eeprom_oe_n = 1'b1;
            end
            default: bus_out = BUS_IDLE;
        endcase
    end

endmodule

// File: rtl/boot_handover.sv
// Boot sequencer: resets the copier, lets it fill RAM, inserts a dead-bus gap,
// then hands RAM to the CPU and releases CPU reset. A watchdog on the copy
// phase parks the system in a sticky fault.
module boot_handover
    import boot_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES   = 40000,
    parameter int unsigned GAP_CYCLES       = 4,
    parameter int unsigned CPU_RESET_CYCLES = 16
) (
    input  logic            clock,
    input  logic            reset_n,
    boot_handover_if.master bus
);

    localparam logic [BOOT_CNT_W-1:0] TIMEOUT_LAST   = BOOT_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [BOOT_CNT_W-1:0] GAP_LAST       = BOOT_CNT_W'(GAP_CYCLES - 1);
    localparam logic [BOOT_CNT_W-1:0] CPU_RESET_LAST = BOOT_CNT_W'(CPU_RESET_CYCLES - 1);

    boot_state_e           state;
    logic [BOOT_CNT_W-1:0] cnt;
    bus_owner_e            owner;
    logic                  copier_reset_n_q;
    logic                  cpu_reset_n_q;
    logic                  booted_q;
    logic                  fault_q;
    mem_bus_t              mux_bus;

    // Status outputs and bus owner are registered alongside the state, so they
    // always equal the decode of the current state without extra latency.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state            <= ST_RESET_COPIER;
            cnt              <= '0;
            owner            <= OWNER_NONE;
            copier_reset_n_q <= 1'b0;
            cpu_reset_n_q    <= 1'b0;
            booted_q         <= 1'b0;
            fault_q          <= 1'b0;
        end else begin
            case (state)
                ST_RESET_COPIER: begin
                    state            <= ST_COPY;
                    cnt              <= '0;
                    owner            <= OWNER_COPIER;
                    copier_reset_n_q <= 1'b1;
                end
                ST_COPY: begin
                    if (bus.copier_done) begin
                        state <= ST_GAP;
                        cnt   <= '0;
                        owner <= OWNER_NONE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        state   <= ST_FAULT;
                        cnt     <= '0;
                        owner   <= OWNER_NONE;
                        fault_q <= 1'b1;
                    end else begin
                        cnt <= cnt + BOOT_CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt == GAP_LAST) begin
                        state <= ST_CPU_RESET;
                        cnt   <= '0;
                        owner <= OWNER_CPU;
                    end else begin
                        cnt <= cnt + BOOT_CNT_W'(1);
                    end
                end
                ST_CPU_RESET: begin
                    if (cnt == CPU_RESET_LAST) begin
                        state         <= ST_RUN;
                        cnt           <= '0;
                        cpu_reset_n_q <= 1'b1;
                        booted_q      <= 1'b1;
                    end else begin
                        cnt <= cnt + BOOT_CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    state <= ST_RUN;
                end
                ST_FAULT: begin
                    state <= ST_FAULT;
                end
                default: begin
                    state            <= ST_FAULT;
                    cnt              <= '0;
                    owner            <= OWNER_NONE;
                    copier_reset_n_q <= 1'b1;
                    cpu_reset_n_q    <= 1'b0;
                    booted_q         <= 1'b0;
                    fault_q          <= 1'b1;
                end
            endcase
        end
    end

    boot_bus_mux u_bus_mux (
        .owner              (owner),
        .copier_address     (bus.copier_address),
        .copier_ram_we_n    (bus.copier_ram_we_n),
        .copier_ram_cs_n    (bus.copier_ram_cs_n),
        .copier_eeprom_oe_n (bus.copier_eeprom_oe_n),
        .copier_eeprom_cs_n (bus.copier_eeprom_cs_n),
        .cpu_address        (bus.cpu_address),
        .cpu_mreq_n         (bus.cpu_mreq_n),
        .cpu_rd_n           (bus.cpu_rd_n),
        .cpu_wr_n           (bus.cpu_wr_n),
        .bus_out            (mux_bus)
    );

    assign bus.copier_reset_n = copier_reset_n_q;
    assign bus.cpu_reset_n    = cpu_reset_n_q;
    assign bus.booted         = booted_q;
    assign bus.fault          = fault_q;
    assign bus.address        = mux_bus.address;
    assign bus.ram_cs_n       = mux_bus.ram_cs_n;
    assign bus.ram_we_n       = mux_bus.ram_we_n;
    assign bus.ram_oe_n       = mux_bus.ram_oe_n;
    assign bus.eeprom_cs_n    = mux_bus.eeprom_cs_n;
    assign bus.eeprom_oe_n    = mux_bus.eeprom_oe_n;

endmodule

// File: tb/tb_boot_handover.sv
// Scoreboard bench for boot_handover: two instances (default timing and a
// short-timeout variant) share the same randomized stimulus; a timestamp
// model predicts every cycle's outputs and a negedge monitor checks them.
module tb_boot_handover;

    localparam int TA = 40000;
    localparam int GA = 4;
    localparam int CA = 16;
    localparam int TB_T = 100;
    localparam int GB = 3;
    localparam int CB = 5;

    localparam int PH_RST   = 0;
    localparam int PH_COPY  = 1;
    localparam int PH_GAP   = 2;
    localparam int PH_CPURST = 3;
    localparam int PH_RUN   = 4;
    localparam int PH_FAULT = 5;

    typedef struct {
        logic [24:0] a;
        logic [24:0] b;
        int          cyc;
    } exp_t;

    logic        clock;
    logic        reset_n;
    logic [15:0] copier_address;
    logic        copier_ram_we_n;
    logic        copier_ram_cs_n;
    logic        copier_eeprom_oe_n;
    logic        copier_eeprom_cs_n;
    logic        copier_done;
    logic [15:0] cpu_address;
    logic        cpu_mreq_n;
    logic        cpu_rd_n;
    logic        cpu_wr_n;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    exp_t sb_q[$];

    // Model: edges since the last reset edge, and the edge at which each
    // instance accepted done (-1 while none).
    int rel = 0;
    int d_a = -1;
    int d_b = -1;
    bit model_valid = 0;

    boot_handover_if bus_a ();
    boot_handover_if bus_b ();

    assign bus_a.copier_address     = copier_address;
    assign bus_a.copier_ram_we_n    = copier_ram_we_n;
    assign bus_a.copier_ram_cs_n    = copier_ram_cs_n;
    assign bus_a.copier_eeprom_oe_n = copier_eeprom_oe_n;
    assign bus_a.copier_eeprom_cs_n = copier_eeprom_cs_n;
    assign bus_a.copier_done        = copier_done;
    assign bus_a.cpu_address        = cpu_address;
    assign bus_a.cpu_mreq_n         = cpu_mreq_n;
    assign bus_a.cpu_rd_n           = cpu_rd_n;
    assign bus_a.cpu_wr_n           = cpu_wr_n;

    assign bus_b.copier_address     = copier_address;
    assign bus_b.copier_ram_we_n    = copier_ram_we_n;
    assign bus_b.copier_ram_cs_n    = copier_ram_cs_n;
    assign bus_b.copier_eeprom_oe_n = copier_eeprom_oe_n;
    assign bus_b.copier_eeprom_cs_n = copier_eeprom_cs_n;
    assign bus_b.copier_done        = copier_done;
    assign bus_b.cpu_address        = cpu_address;
    assign bus_b.cpu_mreq_n         = cpu_mreq_n;
    assign bus_b.cpu_rd_n           = cpu_rd_n;
    assign bus_b.cpu_wr_n           = cpu_wr_n;

    boot_handover #(
        .TIMEOUT_CYCLES   (TA),
        .GAP_CYCLES       (GA),
        .CPU_RESET_CYCLES (CA)
    ) dut_a (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_a)
    );

    boot_handover #(
        .TIMEOUT_CYCLES   (TB_T),
        .GAP_CYCLES       (GB),
        .CPU_RESET_CYCLES (CB)
    ) dut_b (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_b)
    );

    // Free-running clock, period 10.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Phase after the most recent edge, derived from timestamps only.
    function automatic int phase_of(input int r, input int d, input int t,
                                    input int g, input int c);
        if (r == 0) return PH_RST;
        if (d < 0) return (r <= t) ? PH_COPY : PH_FAULT;
        if (r < d) return PH_COPY;
        if (r < d + g) return PH_GAP;
        if (r < d + g + c) return PH_CPURST;
        return PH_RUN;
    endfunction

    // Expected outputs {copier_reset_n, cpu_reset_n, booted, fault, address, ram_cs_n, ram_we_n, ram_oe_n, eeprom_cs_n, eeprom_oe_n}.
    function automatic logic [24:0] expect_out(input int ph);
        logic        crst, prst, bt, flt;
        logic [15:0] adr;
        logic        rcs, rwe, roe, ecs, eoe;
        crst = (ph != PH_RST);
        prst = (ph == PH_RUN);
        bt   = (ph == PH_RUN);
        flt  = (ph == PH_FAULT);
        adr = 16'h0000; rcs = 1'b1; rwe = 1'b1; roe = 1'b1; ecs = 1'b1; eoe = 1'b1;
        if (ph == PH_COPY) begin
            adr = copier_address;
            rcs = copier_ram_cs_n;
            rwe = copier_ram_we_n;
            ecs = copier_eeprom_cs_n;
            eoe = copier_eeprom_oe_n;
        end else if (ph == PH_CPURST || ph == PH_RUN) begin
            adr = cpu_address;
            rcs = cpu_mreq_n;
            roe = cpu_mreq_n | cpu_rd_n;
            rwe = cpu_mreq_n | cpu_wr_n;
        end
        return {crst, prst, bt, flt, adr, rcs, rwe, roe, ecs, eoe};
    endfunction

    // One cycle: drive inputs, predict this cycle's outputs, advance the model at the edge.
    task automatic step(input logic rst_v, input logic done_v, input int mode);
        exp_t e;
        reset_n            = rst_v;
        copier_done        = done_v;
        copier_address     = 16'($urandom);
        copier_ram_we_n    = 1'($urandom);
        copier_ram_cs_n    = 1'($urandom);
        copier_eeprom_oe_n = 1'($urandom);
        copier_eeprom_cs_n = 1'($urandom);
        cpu_address        = 16'($urandom);
        cpu_mreq_n         = 1'($urandom);
        cpu_rd_n           = 1'($urandom);
        cpu_wr_n           = 1'($urandom);
        if (mode == 1) begin
            copier_address  = 16'hE123;
            copier_ram_we_n = 1'b0;
            copier_ram_cs_n = 1'b0;
        end else if (mode == 2) begin
            cpu_address = 16'h0042;
            cpu_mreq_n  = 1'b0;
            cpu_rd_n    = 1'b0;
            cpu_wr_n    = 1'b1;
        end
        if (model_valid) begin
            e.a   = expect_out(phase_of(rel, d_a, TA, GA, CA));
            e.b   = expect_out(phase_of(rel, d_b, TB_T, GB, CB));
            e.cyc = cyc;
            sb_q.push_back(e);
        end
        @(posedge clock);
        if (!rst_v) begin
            rel = 0;
            d_a = -1;
            d_b = -1;
            model_valid = 1;
        end else if (model_valid) begin
            rel++;
            if (done_v) begin
                if (d_a < 0 && rel >= 2 && rel <= TA + 1) d_a = rel;
                if (d_b < 0 && rel >= 2 && rel <= TB_T + 1) d_b = rel;
            end
        end
        cyc++;
        #1;
    endtask

    // Run with reset high until rel reaches stop; done is sampled high from edge done_at on.
    task automatic run_boot(input int done_at, input int stop, input bit mux);
        int mode;
        while (rel < stop) begin
            mode = 0;
            if (mux && rel == 200) mode = 1;
            if (mux && rel >= done_at + GA + CA + 3 && rel < done_at + GA + CA + 6) mode = 2;
            step(1'b1, (rel + 1 >= done_at), mode);
        end
    endtask

    // Monitor: every cycle the DUTs present outputs, pop the prediction and compare.
    always @(negedge clock) begin
        exp_t e;
        logic [24:0] act_a, act_b;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            act_a = {bus_a.copier_reset_n, bus_a.cpu_reset_n, bus_a.booted, bus_a.fault,
                     bus_a.address, bus_a.ram_cs_n, bus_a.ram_we_n, bus_a.ram_oe_n,
                     bus_a.eeprom_cs_n, bus_a.eeprom_oe_n};
            act_b = {bus_b.copier_reset_n, bus_b.cpu_reset_n, bus_b.booted, bus_b.fault,
                     bus_b.address, bus_b.ram_cs_n, bus_b.ram_we_n, bus_b.ram_oe_n,
                     bus_b.eeprom_cs_n, bus_b.eeprom_oe_n};
            tests++;
            if (act_a !== e.a) begin
                fails++;
                $display("FAIL dut_a_outputs cycle %0d: got %h expected %h", e.cyc, act_a, e.a);
            end
            tests++;
            if (act_b !== e.b) begin
                fails++;
                $display("FAIL dut_b_outputs cycle %0d: got %h expected %h", e.cyc, act_b, e.b);
            end
        end
    end

    // Global time bound.
    initial begin
        #2000000;
        $display("FAIL sim_timeout: simulation did not finish in time");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "time limit");
    end

    initial begin
        step(1'b0, 1'b0, 0);

        // Full-size copy: A boots after 32768 COPY cycles, B times out long before and ignores done.
        run_boot(32769, 32769 + GA + CA + 30, 1'b1);

        // Short copies of random length; B faults whenever done comes after its watchdog.
        for (int k = 0; k < 5; k++) begin
            int dn;
            dn = (k == 0) ? 2 : int'($urandom_range(3, 140));
            step(1'b0, 1'b0, 0);
            run_boot(dn, dn + GA + CA + 20, 1'b1);
        end

        // Done arriving in B's final watchdog cycle: done takes priority.
        step(1'b0, 1'b0, 0);
        run_boot(TB_T + 1, TB_T + 1 + GA + CA + 20, 1'b0);

        // Done one cycle too late for B: fault.
        step(1'b0, 1'b0, 0);
        run_boot(TB_T + 2, TB_T + 2 + GA + CA + 20, 1'b0);

        // Reset pulse mid-copy, then a full boot, then a reset pulse in RUN.
        step(1'b0, 1'b0, 0);
        run_boot(300, 50, 1'b0);
        step(1'b0, 1'b0, 0);
        run_boot(80, 80 + GA + CA + 20, 1'b1);
        step(1'b0, 1'b0, 0);
        run_boot(60, 60 + GA + CA + 20, 1'b1);

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clock);
        #1;
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
